// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - MIPS32 instruction fetch and PC sequencing
// Optional macro FETCH_TIMEOUT_EN adds a fetch watchdog with a sticky error and HALT state.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  input  logic        ex_done,
  input  logic        Branch,
  input  logic        Brchne,
  input  logic        Jump,
  input  logic        Jal,
  input  logic        zero,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;

  state_t      state, state_nx;
  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] next_pc;
  logic        timeout_hit;

  // jal only matters to the register-file write port; link_addr serves it here
  logic unused_jal;
  assign unused_jal = Jal;

  assign pc4         = pc + 32'd4;
  assign br_off      = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign imem_req    = (state == FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == ISSUE);
  assign opcode      = instr[31:26];
  assign link_addr   = pc4;

  // Jump is tested first so X on the branch strobes cannot leak into the result
  always_comb begin
    next_pc = pc4;
    if (Jump) begin
      next_pc = {pc4[31:28], instr[25:0], 2'b00};
    end else if ((Branch && zero) || (Brchne && !zero)) begin
      next_pc = pc4 + br_off;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] to_cnt;

  assign timeout_hit = (state == FETCH) && !imem_ack && (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  // counter idles at zero outside FETCH, so every FETCH entry starts a fresh window
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt    <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (state == FETCH && !imem_ack) begin
        to_cnt <= to_cnt + 1'b1;
      end else begin
        to_cnt <= '0;
      end
      if (timeout_hit) begin
        fetch_err <= 1'b1;
      end
    end
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;

  assign timeout_hit = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = FETCH;
      FETCH: begin
        if (imem_ack) begin
          state_nx = ISSUE;
        end else if (timeout_hit) begin
          state_nx = HALT;
        end
      end
      ISSUE: begin
        if (ex_done) begin
          state_nx = FETCH;
        end
      end
      HALT:    state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= RESET_PC;
      instr <= 32'd0;
    end else begin
      if (state == FETCH && imem_ack) begin
        instr <= imem_rdata;
      end
      if (state == ISSUE && ex_done) begin
        pc <= {next_pc[31:2], 2'b00};
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
// Define FETCH_TIMEOUT_EN to also exercise the fetch watchdog.
module tb_fetch_sequencer;

  localparam logic [31:0] RPC = 32'h0040_0000;
`ifdef FETCH_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        ex_done;
  logic        Branch;
  logic        Brchne;
  logic        Jump;
  logic        Jal;
  logic        zero;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        fetch_err;

  fetch_sequencer #(.RESET_PC(RPC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
    .instr_valid(instr_valid), .ex_done(ex_done), .Branch(Branch), .Brchne(Brchne),
    .Jump(Jump), .Jal(Jal), .zero(zero), .pc(pc), .link_addr(link_addr),
    .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] mpc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference next-PC from the architectural rules of j/beq/bne
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] iw,
                                             input logic j, input logic br, input logic bne,
                                             input logic z);
    logic [31:0] p4;
    int          off;
    p4 = p + 32'd4;
    if (j === 1'b1) return (p4 & 32'hF000_0000) | ((iw & 32'h03FF_FFFF) << 2);
    off = int'($signed(iw[15:0]));
    if ((br === 1'b1 && z === 1'b1) || (bne === 1'b1 && z === 1'b0)) return p4 + 32'(off * 4);
    return p4;
  endfunction

  task automatic rand_strobes();
    Branch = 1'($urandom); Brchne = 1'($urandom); Jump = 1'($urandom);
    Jal = 1'($urandom); zero = 1'($urandom);
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic fetch_word(input logic [31:0] iw, input int waits);
    wait_req();
    chk("imem_addr", imem_addr, mpc);
    chk("valid_in_fetch", {31'd0, instr_valid}, 32'd0);
    for (int w = 0; w < waits; w++) begin
      imem_rdata = $urandom;
      ex_done = 1'($urandom);
      @(negedge clk);
      chk("addr_stable", imem_addr, mpc);
      chk("req_held", {31'd0, imem_req}, 32'd1);
    end
    imem_ack = 1'b1;
    imem_rdata = iw;
    @(negedge clk);
    imem_ack = 1'b0;
    ex_done = 1'b0;
    imem_rdata = $urandom;
    chk("valid_issue", {31'd0, instr_valid}, 32'd1);
    chk("instr", instr, iw);
    chk("opcode", {26'd0, opcode}, iw >> 26);
    chk("pc", pc, mpc);
    chk("link_addr", link_addr, mpc + 32'd4);
    chk("req_drop", {31'd0, imem_req}, 32'd0);
    chk("fetch_err_low", {31'd0, fetch_err}, 32'd0);
  endtask

  task automatic run_instr(input logic [31:0] iw, input int waits, input int hold,
                           input logic j, input logic jl, input logic br,
                           input logic bne, input logic z);
    fetch_word(iw, waits);
    for (int h = 0; h < hold; h++) begin
      rand_strobes();
      imem_ack = 1'($urandom);
      imem_rdata = $urandom;
      @(negedge clk);
      chk("hold_valid", {31'd0, instr_valid}, 32'd1);
      chk("hold_instr", instr, iw);
      chk("hold_pc", pc, mpc);
    end
    imem_ack = 1'($urandom);
    ex_done = 1'b1;
    Jump = j; Jal = jl; Branch = br; Brchne = bne; zero = z;
    @(negedge clk);
    ex_done = 1'b0;
    imem_ack = 1'b0;
    rand_strobes();
    mpc = model_next(mpc, iw, j, br, bne, z);
    chk("valid_drop", {31'd0, instr_valid}, 32'd0);
    chk("refetch_req", {31'd0, imem_req}, 32'd1);
    chk("next_addr", imem_addr, mpc);
  endtask

  initial begin
    reset = 1'b1;
    imem_ack = 1'b0; imem_rdata = 32'd0; ex_done = 1'b0;
    Branch = 1'b0; Brchne = 1'b0; Jump = 1'b0; Jal = 1'b0; zero = 1'b0;
    mpc = RPC;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc", pc, RPC);
    chk("rst_instr", instr, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("first_fetch_req", {31'd0, imem_req}, 32'd1);

    // sequential fetch at zero wait
    run_instr(32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("seq_addr", imem_addr, 32'h0040_0004);
    run_instr(32'h2408_0001, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // j 0x100, then beq taken / not taken
    run_instr(32'h0800_0040, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("j_target", imem_addr, 32'h0000_0100);
    run_instr(32'h1000_0003, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("beq_taken", imem_addr, 32'h0000_0110);
    run_instr(32'h0800_0040, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(32'h1000_0003, 2, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("beq_not_taken", imem_addr, 32'h0000_0104);
    // bne with negative offset loops onto itself
    run_instr(32'h0800_0080, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(32'h1400_FFFF, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bne_back", imem_addr, 32'h0000_0200);
    run_instr(32'h0800_00C0, 0, 0, 1'b1, 1'b0, 1'bx, 1'bx, 1'b0);

    // async reset in the middle of ISSUE at 0x300, then a late ack
    fetch_word(32'h2129_0005, 0);
    chk("pre_rst_pc", pc, 32'h0000_0300);
    #2 reset = 1'b1;
    imem_ack = 1'b1;
    #1;
    chk("async_valid", {31'd0, instr_valid}, 32'd0);
    chk("async_req", {31'd0, imem_req}, 32'd0);
    chk("async_pc", pc, RPC);
    @(negedge clk);
    reset = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 imem_ack = 1'b0;
    @(negedge clk);
    mpc = RPC;
    chk("late_ack_instr", instr, 32'd0);
    chk("late_ack_req", {31'd0, imem_req}, 32'd1);
    chk("late_ack_addr", imem_addr, RPC);

    // reach 0x10000000 via j to 0x0FFFFFFC and a nop, then jal
    run_instr(32'h0BFF_FFFF, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("j_top", imem_addr, 32'h0FFF_FFFC);
    run_instr(32'h0000_0000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr(32'h0C00_0040, 0, 0, 1'b1, 1'b1, 1'bx, 1'b0, 1'b1);
    chk("jal_target", imem_addr, 32'h1000_0100);

    for (int i = 0; i < 40; i++) begin
      logic j, br, bne, z;
      j   = ($urandom_range(0, 3) == 0);
      br  = 1'($urandom);
      bne = 1'($urandom);
      z   = 1'($urandom);
      if (j && $urandom_range(0, 1) == 1) br = 1'bx;
      run_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 2), j, 1'($urandom), br, bne, z);
    end

`ifdef FETCH_TIMEOUT_EN
    begin
      int reqs;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      imem_ack = 1'b0;
      @(negedge clk);
      reqs = 0;
      while (imem_req === 1'b1 && reqs < 20) begin
        @(negedge clk);
        reqs++;
      end
      chk("to_req_cycles", 32'(reqs), 32'(TO));
      chk("to_err", {31'd0, fetch_err}, 32'd1);
      chk("to_req_low", {31'd0, imem_req}, 32'd0);
      imem_ack = 1'b1;
      ex_done = 1'b1;
      repeat (3) @(negedge clk);
      imem_ack = 1'b0;
      ex_done = 1'b0;
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);
      chk("halt_err", {31'd0, fetch_err}, 32'd1);
      reset = 1'b1;
      #1;
      chk("halt_rst_err", {31'd0, fetch_err}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
